// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: sequences one single-ported unified memory between the
// OTTER instruction-fetch (IF) port and data-memory (DM) port, one
// transaction at a time, and drives per-port stall signals.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   if_rden, if_addr                fetch request (level) and address
//   if_dout, if_valid, if_stall     fetch data, completion pulse, stall
//   dm_rden, dm_we, dm_addr,        data request (read / write), address,
//   dm_din, dm_size                 store data, access size
//   dm_dout, dm_done, dm_stall      load data, completion pulse, stall
//   mem_req, mem_we, mem_addr,      memory transaction start pulse and
//   mem_din, mem_size               latched write qualifier / address / data / size
//   mem_rdata, mem_ack              memory read data and completion pulse
//
// Build option: define OTTER_MEM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise the DM port has fixed priority.
module otter_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_rden,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_dout,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_rden,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_din,
  input  logic [1:0]        dm_size,
  output logic [DATA_W-1:0] dm_dout,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t            state_q, state_d;
  logic              mem_req_d, mem_we_d, if_valid_d, dm_done_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_din_d, if_dout_d, dm_dout_d;
  logic [1:0]        mem_size_d;
  logic              if_elig, dm_elig, grant_dm;

  // A port is not eligible in its own completion cycle (forces one bubble).
  assign if_elig = if_rden & ~if_valid;
  assign dm_elig = (dm_rden | dm_we) & ~dm_done;

  assign if_stall = if_rden & ~if_valid;
  assign dm_stall = (dm_rden | dm_we) & ~dm_done;

`ifdef OTTER_MEM_ARB_RR_EN
  // last_grant: 0 = IF won most recently, 1 = DM won most recently.
  logic last_grant_q, last_grant_d;

  assign grant_dm = dm_elig & (~if_elig | ~last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`else
  // DM request belongs to the older instruction, so it wins contention.
  assign grant_dm = dm_elig;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = 1'b0;
    mem_we_d   = mem_we;
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
    mem_size_d = mem_size;
    if_dout_d  = if_dout;
    dm_dout_d  = dm_dout;
    if_valid_d = 1'b0;
    dm_done_d  = 1'b0;
`ifdef OTTER_MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d    = BUSY_DM;
          mem_req_d  = 1'b1;
          mem_we_d   = dm_we;
          mem_addr_d = dm_addr;
          mem_din_d  = dm_din;
          mem_size_d = dm_size;
`ifdef OTTER_MEM_ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (if_elig) begin
          state_d    = BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_din_d  = '0;
          mem_size_d = SIZE_WORD;
`ifdef OTTER_MEM_ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_d    = IDLE;
          if_dout_d  = mem_rdata;
          if_valid_d = 1'b1;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          state_d   = IDLE;
          dm_done_d = 1'b1;
          if (!mem_we) dm_dout_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_size <= '0;
      if_dout  <= '0;
      dm_dout  <= '0;
      if_valid <= 1'b0;
      dm_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_req  <= mem_req_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_din  <= mem_din_d;
      mem_size <= mem_size_d;
      if_dout  <= if_dout_d;
      dm_dout  <= dm_dout_d;
      if_valid <= if_valid_d;
      dm_done  <= dm_done_d;
    end
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: cycle-by-cycle vector table for
// store, fetch and contention, plus sequences for back-to-back fetch, grant
// order under continuous contention and reset in the middle of a transaction.
module tb_otter_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_rden;
  logic [31:0] if_addr;
  logic [31:0] if_dout;
  logic        if_valid, if_stall;
  logic        dm_rden, dm_we;
  logic [31:0] dm_addr, dm_din;
  logic [1:0]  dm_size;
  logic [31:0] dm_dout;
  logic        dm_done, dm_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_din;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_total = 0;
  int n_pass  = 0;

  otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_rden(if_rden), .if_addr(if_addr), .if_dout(if_dout),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_rden(dm_rden), .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_size(dm_size), .dm_dout(dm_dout), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_rden;
    logic [31:0] if_addr;
    logic        dm_rden;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic [1:0]  dm_size;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic [1:0]  e_size;
    logic        e_ifv;
    logic [31:0] e_ifdout;
    logic        e_ifst;
    logic        e_dmd;
    logic [31:0] e_dmdout;
    logic        e_dmst;
  } vec_t;

  localparam int unsigned NVEC = 20;
  vec_t vecs [NVEC];

  function automatic vec_t v(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd, input logic [1:0] ds,
    input logic [31:0] rd, input logic ak,
    input logic req, input logic we, input logic [31:0] ma, input logic [31:0] md,
    input logic [1:0] ms, input logic iv, input logic [31:0] idt, input logic ist,
    input logic dmd, input logic [31:0] ddt, input logic dst);
    vec_t r;
    r.if_rden = ir; r.if_addr = ia; r.dm_rden = dr; r.dm_we = dw;
    r.dm_addr = da; r.dm_din = dd; r.dm_size = ds; r.mem_rdata = rd; r.mem_ack = ak;
    r.e_req = req; r.e_we = we; r.e_addr = ma; r.e_din = md; r.e_size = ms;
    r.e_ifv = iv; r.e_ifdout = idt; r.e_ifst = ist; r.e_dmd = dmd;
    r.e_dmdout = ddt; r.e_dmst = dst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive_idle();
    if_rden = 1'b0; if_addr = '0; dm_rden = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_din = '0; dm_size = '0; mem_rdata = '0; mem_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"},  32'(mem_req), 32'h0);
    chk({tag, " mem_we"},   32'(mem_we), 32'h0);
    chk({tag, " mem_addr"}, mem_addr, 32'h0);
    chk({tag, " mem_din"},  mem_din, 32'h0);
    chk({tag, " mem_size"}, 32'(mem_size), 32'h0);
    chk({tag, " if_dout"},  if_dout, 32'h0);
    chk({tag, " if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, " dm_dout"},  dm_dout, 32'h0);
    chk({tag, " dm_done"},  32'(dm_done), 32'h0);
  endtask

  // Advance to the next negedge; the caller drives inputs then waits #1 to sample.
  task automatic step();
    @(negedge clk);
  endtask

  logic [31:0] exp_order [4];
  bit          seen;

  initial begin
    drive_idle();
    rst_n = 1'b0;

    // Store, then fetch, then IF/DM contention with DM winning.
    //          ir  ia        dr dw da        dd            ds     rd            ak | req we ma        md            ms     iv idt           ist dmd ddt           dst
    vecs[0]  = v(0, 32'h0,    0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 32'h0,        0,  0, 0, 32'h0,    32'h0,        2'b00, 0, 32'h0,        0, 0, 32'h0,        1);
    vecs[1]  = v(0, 32'h0,    0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 32'h0,        0,  1, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 0, 32'h0,        1);
    vecs[2]  = v(0, 32'h0,    0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 32'h0,        0,  0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 0, 32'h0,        1);
    vecs[3]  = v(0, 32'h0,    0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 32'h0,        0,  0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 0, 32'h0,        1);
    vecs[4]  = v(0, 32'h0,    0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 32'h12345678, 1,  0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 0, 32'h0,        1);
    vecs[5]  = v(0, 32'h0,    0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 1, 32'h0,        0);
    vecs[6]  = v(0, 32'h0,    0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 0, 32'h0,        0);
    vecs[7]  = v(1, 32'h100,  0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  0, 1, 32'h2000, 32'hDEADBEEF, 2'b10, 0, 32'h0,        1, 0, 32'h0,        0);
    vecs[8]  = v(1, 32'h100,  0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  1, 0, 32'h100,  32'h0,        2'b10, 0, 32'h0,        1, 0, 32'h0,        0);
    vecs[9]  = v(1, 32'h100,  0, 0, 32'h0,    32'h0,        2'b00, 32'h00500093, 1,  0, 0, 32'h100,  32'h0,        2'b10, 0, 32'h0,        1, 0, 32'h0,        0);
    vecs[10] = v(1, 32'h100,  0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  0, 0, 32'h100,  32'h0,        2'b10, 1, 32'h00500093, 0, 0, 32'h0,        0);
    vecs[11] = v(0, 32'h0,    0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  0, 0, 32'h100,  32'h0,        2'b10, 0, 32'h00500093, 0, 0, 32'h0,        0);
    vecs[12] = v(1, 32'h104,  1, 0, 32'h3000, 32'h0,        2'b01, 32'h0,        0,  0, 0, 32'h100,  32'h0,        2'b10, 0, 32'h00500093, 1, 0, 32'h0,        1);
    vecs[13] = v(1, 32'h104,  1, 0, 32'h3000, 32'h0,        2'b01, 32'h0,        0,  1, 0, 32'h3000, 32'h0,        2'b01, 0, 32'h00500093, 1, 0, 32'h0,        1);
    vecs[14] = v(1, 32'h104,  1, 0, 32'h3000, 32'h0,        2'b01, 32'hCAFEF00D, 1,  0, 0, 32'h3000, 32'h0,        2'b01, 0, 32'h00500093, 1, 0, 32'h0,        1);
    vecs[15] = v(1, 32'h104,  0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  0, 0, 32'h3000, 32'h0,        2'b01, 0, 32'h00500093, 1, 1, 32'hCAFEF00D, 0);
    vecs[16] = v(1, 32'h104,  0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  1, 0, 32'h104,  32'h0,        2'b10, 0, 32'h00500093, 1, 0, 32'hCAFEF00D, 0);
    vecs[17] = v(1, 32'h104,  0, 0, 32'h0,    32'h0,        2'b00, 32'h00A00113, 1,  0, 0, 32'h104,  32'h0,        2'b10, 0, 32'h00500093, 1, 0, 32'hCAFEF00D, 0);
    vecs[18] = v(1, 32'h104,  0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  0, 0, 32'h104,  32'h0,        2'b10, 1, 32'h00A00113, 0, 0, 32'hCAFEF00D, 0);
    vecs[19] = v(0, 32'h0,    0, 0, 32'h0,    32'h0,        2'b00, 32'h0,        0,  0, 0, 32'h104,  32'h0,        2'b10, 0, 32'h00A00113, 0, 0, 32'hCAFEF00D, 0);

    // Reset state.
    #12;
    chk_all_zero("reset");
    chk("reset if_stall", 32'(if_stall), 32'h0);
    chk("reset dm_stall", 32'(dm_stall), 32'h0);
    step();
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < int'(NVEC); i++) begin
      step();
      if_rden = vecs[i].if_rden; if_addr = vecs[i].if_addr;
      dm_rden = vecs[i].dm_rden; dm_we = vecs[i].dm_we;
      dm_addr = vecs[i].dm_addr; dm_din = vecs[i].dm_din; dm_size = vecs[i].dm_size;
      mem_rdata = vecs[i].mem_rdata; mem_ack = vecs[i].mem_ack;
      #1;
      chk($sformatf("v%0d mem_req", i),  32'(mem_req),  32'(vecs[i].e_req));
      chk($sformatf("v%0d mem_we", i),   32'(mem_we),   32'(vecs[i].e_we));
      chk($sformatf("v%0d mem_addr", i), mem_addr,      vecs[i].e_addr);
      chk($sformatf("v%0d mem_din", i),  mem_din,       vecs[i].e_din);
      chk($sformatf("v%0d mem_size", i), 32'(mem_size), 32'(vecs[i].e_size));
      chk($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_ifv));
      chk($sformatf("v%0d if_dout", i),  if_dout,       vecs[i].e_ifdout);
      chk($sformatf("v%0d if_stall", i), 32'(if_stall), 32'(vecs[i].e_ifst));
      chk($sformatf("v%0d dm_done", i),  32'(dm_done),  32'(vecs[i].e_dmd));
      chk($sformatf("v%0d dm_dout", i),  dm_dout,       vecs[i].e_dmdout);
      chk($sformatf("v%0d dm_stall", i), 32'(dm_stall), 32'(vecs[i].e_dmst));
    end

    // Back-to-back fetch with if_rden held: one bubble, no duplicate request.
    step(); drive_idle(); if_rden = 1'b1; if_addr = 32'h200; #1;
    chk("b2b s0 mem_req", 32'(mem_req), 32'h0);
    step(); #1;
    chk("b2b s1 mem_req", 32'(mem_req), 32'h1);
    chk("b2b s1 mem_addr", mem_addr, 32'h200);
    step(); mem_ack = 1'b1; mem_rdata = 32'h11; #1;
    chk("b2b s2 mem_req", 32'(mem_req), 32'h0);
    step(); mem_ack = 1'b0; #1;
    chk("b2b s3 if_valid", 32'(if_valid), 32'h1);
    chk("b2b s3 if_dout", if_dout, 32'h11);
    chk("b2b s3 no dup req", 32'(mem_req), 32'h0);
    step(); #1;
    chk("b2b s4 bubble req", 32'(mem_req), 32'h0);
    chk("b2b s4 if_valid", 32'(if_valid), 32'h0);
    chk("b2b s4 if_stall", 32'(if_stall), 32'h1);
    step(); #1;
    chk("b2b s5 mem_req", 32'(mem_req), 32'h1);
    step(); mem_ack = 1'b1; mem_rdata = 32'h22; #1;
    step(); mem_ack = 1'b0; if_rden = 1'b0; #1;
    chk("b2b s7 if_valid", 32'(if_valid), 32'h1);
    chk("b2b s7 if_dout", if_dout, 32'h22);
    step(); #1;
    chk("b2b s8 mem_req", 32'(mem_req), 32'h0);

    // Both ports held continuously: grant order DM, IF, DM, IF.
    exp_order[0] = 32'h5000; exp_order[1] = 32'h400;
    exp_order[2] = 32'h5000; exp_order[3] = 32'h400;
    step(); if_rden = 1'b1; if_addr = 32'h400; dm_rden = 1'b1; dm_addr = 32'h5000; dm_size = 2'b10;
    #1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        step(); #1;
        if (mem_req) seen = 1'b1;
      end
      chk($sformatf("grant%0d req seen", k), 32'(seen), 32'h1);
      chk($sformatf("grant%0d mem_addr", k), mem_addr, exp_order[k]);
      step(); mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(k); #1;
      step(); mem_ack = 1'b0;
      if (k == 3) begin if_rden = 1'b0; dm_rden = 1'b0; end
      #1;
    end
    chk("grant3 if_valid", 32'(if_valid), 32'h1);
    chk("grant3 if_dout", if_dout, 32'hA3);
    chk("grant dm_dout", dm_dout, 32'hA2);

    // Reset while BUSY_DM, then a stray acknowledge.
    step(); drive_idle(); dm_rden = 1'b1; dm_addr = 32'h6000; #1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      step(); #1;
      if (mem_req) seen = 1'b1;
    end
    chk("rst req seen", 32'(seen), 32'h1);
    step(); #2;
    rst_n = 1'b0; dm_rden = 1'b0; #1;
    chk_all_zero("midrst");
    chk("midrst dm_stall", 32'(dm_stall), 32'h0);
    step(); rst_n = 1'b1;
    step(); mem_ack = 1'b1; mem_rdata = 32'h77; #1;
    step(); mem_ack = 1'b0; #1;
    chk_all_zero("stray ack");
    step(); #1;
    chk("stray ack later dm_done", 32'(dm_done), 32'h0);
    chk("stray ack later mem_req", 32'(mem_req), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
